// File: rtl/fir_pkg.sv
// Purpose: shared constants, pointer type and saturation helper for the FIR output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    // avg = (sum + RND_CONST) >> RND_SHIFT : divide-by-4 with round-half-up
    localparam int RND_CONST = 2;
    localparam int RND_SHIFT = 2;

    // Default FIFO depth and the matching pointer type (extra MSB separates full from empty)
    localparam int FIFO_DEPTH = 4;
    typedef logic [$clog2(FIFO_DEPTH):0] fifo_ptr_t;

    // Clamp an unsigned value to the largest w-bit number (w < 32)
    function automatic logic [31:0] sat_w(input logic [31:0] value, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with combinational head, occupancy count and push+pop when full.
// Latency: a push is visible at the head one edge later; head_dat is 0 whenever empty.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W-1:0]             head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Occupancy falls out of the pointer difference; the MSB makes full distinct from empty
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == PW'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; when full with a pop the write lands in the slot being vacated
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/fir_avg_decim.sv
// Purpose: turn the 4-tap FIR sum into a rounded, saturated average, decimate, and buffer it.
// Latency: a kept sample sampled at edge N is at the FIFO head after edge N+1.
// Backpressure: out_valid/out_ready; a kept sample arriving at a full FIFO is dropped and flagged.
module fir_avg_decim
    import fir_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int DW    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [W+1:0]             in_data,
    input  logic [DW-1:0]            decim,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    input  logic                     out_ready,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   level
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dlat_q, dlat_d;
    logic [DW-1:0] decim_eff;
    logic [DW-1:0] lim;
    logic [W+2:0]  avg_full;
    logic [W-1:0]  avg_sat;
    logic          keep;
    logic          rnd_vld_q, rnd_vld_d;
    logic [W-1:0]  rnd_dat_q, rnd_dat_d;
    logic          ovf_q, ovf_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    // A decim of zero means "keep everything"
    assign decim_eff = (decim == '0) ? DW'(1) : decim;

    // Round-half-up divide by 4 at W+3 bits, then clamp to W bits
    assign avg_full = ({1'b0, in_data} + (W+3)'(RND_CONST)) >> RND_SHIFT;
    assign avg_sat  = W'(sat_w(32'(avg_full), W));

    assign keep      = in_valid & (cnt_q == '0);
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign overflow  = ovf_q;

    // Decimation counter: the period is sampled from decim at the kept sample and held until the wrap
    always_comb begin
        cnt_d  = cnt_q;
        dlat_d = dlat_q;
        lim    = (cnt_q == '0) ? decim_eff : dlat_q;
        if (in_valid) begin
            if (cnt_q == '0) dlat_d = decim_eff;
            cnt_d = (cnt_q == lim - DW'(1)) ? '0 : cnt_q + DW'(1);
        end
    end

    // Round stage and sticky overflow (a new drop beats a clear on the same edge)
    always_comb begin
        rnd_vld_d = keep;
        rnd_dat_d = keep ? avg_sat : rnd_dat_q;
        ovf_d     = ovf_q;
        if (rnd_vld_q && fifo_full && !pop) ovf_d = 1'b1;
        else if (clr_ovf)                   ovf_d = 1'b0;
    end

    // Pipeline state, cleared asynchronously so in-flight samples vanish on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            dlat_q    <= '0;
            rnd_vld_q <= 1'b0;
            rnd_dat_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dlat_q    <= dlat_d;
            rnd_vld_q <= rnd_vld_d;
            rnd_dat_q <= rnd_dat_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (rnd_vld_q),
        .push_dat (rnd_dat_q),
        .pop      (out_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level),
        .head_dat (out_data)
    );

endmodule

// File: tb/tb_fir_avg_decim.sv
// Purpose: randomized + directed bench for fir_avg_decim with a queue-based reference model.
// Latency: n/a.
// Backpressure: out_ready is driven both directed and random.
module tb_fir_avg_decim;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int DW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W+1:0]  in_data = '0;
    logic [DW-1:0] decim = '0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic          overflow;
    logic          clr_ovf = 1'b0;
    logic [$clog2(DEPTH):0] level;

    fir_avg_decim #(.W(W), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .decim     (decim),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .level     (level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: expected output stream, FIFO occupancy, sticky flag, pending kept sample
    int exp_q[$];
    int m_level = 0;
    bit m_ovf = 1'b0;
    bit m_pend_vld = 1'b0;
    int m_pend = 0;
    int m_idx = 0;
    int m_next_keep = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_avg(int s);
        int a;
        a = (s + 2) / 4;
        if (a > 65535) a = 65535;
        return a;
    endfunction

    // One clock edge of the reference model, using the inputs that edge sampled
    task automatic model_edge(bit iv, int dat, int dec, bit rdy, bit clr);
        bit pop;
        bit set_ovf;
        pop = (m_level != 0) && rdy;
        set_ovf = 1'b0;
        if (m_pend_vld) begin
            if (m_level < DEPTH || pop) begin
                exp_q.push_back(m_pend);
                m_level++;
            end else begin
                set_ovf = 1'b1;
            end
        end
        if (pop) m_level--;
        if (set_ovf) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_pend_vld = 1'b0;
        if (iv) begin
            if (m_idx == m_next_keep) begin
                m_pend_vld = 1'b1;
                m_pend = ref_avg(dat);
                m_next_keep = m_idx + ((dec == 0) ? 1 : dec);
            end
            m_idx++;
        end
    endtask

    task automatic step(bit iv, int dat, int dec, bit rdy, bit clr);
        in_valid  = iv;
        in_data   = (W+2)'(dat);
        decim     = DW'(dec);
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        model_edge(iv, dat, dec, rdy, clr);
        #1;
    endtask

    // Monitor: mid-cycle, compare status with the model and check every handshake against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("level", int'(level), m_level);
                chk("overflow", int'(overflow), int'(m_ovf));
                chk("out_valid", int'(out_valid), int'(m_level != 0));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pop_unexpected: got data %0d expected no output (t=%0t)", out_data, $time);
                    end else begin
                        chk("out_data", int'(out_data), exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dat;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_out_data", int'(out_data), 0);
        reset = 1'b1;

        // Rounding and latency: sample at edge N shows up after edge N+1
        step(1, 5, 1, 0, 0);
        chk("lat_not_yet", int'(out_valid), 0);
        step(0, 0, 1, 0, 0);
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_data", int'(out_data), 1);
        step(1, 6, 1, 1, 0);
        step(1, 'h3FFFD, 1, 1, 0);
        step(1, 'h3FFFE, 1, 1, 0);
        step(1, 'h3FFFF, 1, 1, 0);
        repeat (3) step(0, 0, 1, 1, 0);
        chk("round_ovf", int'(overflow), 0);

        // Decimation by 3, then a change to 2 on the 2nd input of a period
        for (int k = 1; k <= 9; k++) step(1, 4 * k, 3, 1, 0);
        step(1, 4, 3, 1, 0);
        for (int k = 2; k <= 7; k++) step(1, 4 * k, 2, 1, 0);
        // decim of 0 acts as 1
        for (int k = 0; k < 3; k++) step(1, 4 * k, 0, 1, 0);
        repeat (4) step(0, 0, 1, 1, 0);

        // Backpressure: 4 of 6 samples fit, the rest are dropped
        for (int k = 1; k <= 6; k++) step(1, 4 * k, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("bp_level", int'(level), 4);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_overflow", int'(overflow), 1);
        step(0, 0, 1, 0, 1);
        chk("clr_overflow", int'(overflow), 0);
        // Full FIFO: write and pop on the same edge
        step(1, 28, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("fullpop_level", int'(level), 4);
        chk("fullpop_overflow", int'(overflow), 0);
        repeat (6) step(0, 0, 1, 1, 0);

        // Asynchronous reset with three entries buffered
        for (int k = 1; k <= 3; k++) step(1, 8 * k, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("pre_rst_level", int'(level), 3);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_level", int'(level), 0);
        exp_q.delete();
        m_level = 0;
        m_ovf = 1'b0;
        m_pend_vld = 1'b0;
        m_next_keep = m_idx;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 40, 3, 0, 0);
        chk("post_rst_early", int'(out_valid), 0);
        step(0, 0, 3, 0, 0);
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_data", int'(out_data), 10);
        repeat (3) step(0, 0, 1, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            dat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(262143 - 3, 262143))
                                              : int'($urandom_range(0, 262143));
            step($urandom_range(0, 3) != 0, dat, int'($urandom_range(0, 4)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        // Drain with a bounded budget
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && level == 0) break;
            step(0, 0, 1, 1, 0);
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_level", int'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_avg_decim.md
Name: fir_avg_decim

Overview:
- Output stage placed directly downstream of the 4-tap all-ones transpose FIR.
- Takes the FIR's registered (W+2)-bit sum each cycle and converts it to a W-bit moving average (divide by 4, round-half-up, saturate).
- Applies a runtime decimation factor and buffers the kept samples in a small FIFO.
- Delivers samples over a valid/ready interface and flags overflow when the consumer stalls.

Parameters:
- W, 16, width of FIR input samples; the consumed sum is W+2 bits and the produced average is W bits.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- DW, 4, width of the decimation-factor input.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  in_data holds a sample this cycle; tie to 1 for the free-running FIR.
- in_data  input  W+2  FIR sum s.
- decim  input  DW  keep 1 of every decim samples; 0 is treated as 1.
- out_valid  output  1  FIFO not empty.
- out_data  output  W  FIFO head.
- out_ready  input  1  consumer accepts out_data when out_valid=1.
- overflow  output  1  sticky; a kept sample was dropped because the FIFO was full.
- clr_ovf  input  1  synchronous clear of overflow.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): all of the following go to 0:
  - out_valid, out_data, overflow, level
  - decimation counter, round-stage register and valid, FIFO pointers
  - FIFO contents do not need resetting.
- Reset mid-operation clears everything immediately. Samples in flight are lost and not flagged.
- Rounding arithmetic:
  - avg = (in_data + 2) >> 2, computed at W+3 bits.
  - If avg > 2^W-1, the result saturates to 2^W-1.
  - The only saturating inputs are in_data ≥ 2^(W+2)-2.
- Decimation counter cnt:
  - Counts 0..decim_eff-1, where decim_eff = max(decim,1).
  - Advances only on in_valid=1.
  - A sample is kept when cnt==0. cnt wraps to 0 after decim_eff-1.
  - A decim change takes effect at the next wrap. The comparison uses a latched copy of decim that is reloaded when cnt returns to 0.
  - The first valid sample after reset is always kept.
- Stage 1 (round register):
  - On an edge with in_valid=1 and cnt==0, rnd_data <= saturated avg and rnd_vld <= 1.
  - Otherwise rnd_vld <= 0.
- Stage 2 (FIFO write):
  - On an edge with rnd_vld=1, write if not full, or if full with a simultaneous pop (out_valid & out_ready).
  - If full and no pop, drop the sample and set overflow <= 1. overflow stays 1 until clr_ovf=1.
  - If clr_ovf and a new overflow occur on the same edge, set wins.
- Latency: a sample present at edge N appears on out_valid/out_data after edge N+1 (2-cycle latency when the FIFO is empty).
- Read side:
  - out_data = mem[rd_ptr], driven combinationally from the FIFO.
  - out_valid = (level != 0).
  - Pop occurs on an edge with out_valid & out_ready.
- Occupancy: level updates +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
- Empty: out_ready is ignored and there is no underflow.
- Pointers wrap modulo DEPTH, with an extra MSB to distinguish full from empty.
- Ordering: output order equals kept-sample input order; no reordering.

Decomposition:
- Package fir_pkg:
  - localparams for the rounding constant (2) and shift (2)
  - a saturate function sat_w(value, W)
  - typedef for FIFO pointer width
- One natural sub-module: sync_fifo (parameters DEPTH and data width W; push/pop/full/empty/level; supports simultaneous push and pop when full).
- Decimation and rounding stay in the top module.

Test Plan:
- Rounding, W=16, decim=1, out_ready=1: in_data 5, 6, 0x3FFFD, 0x3FFFE, 0x3FFFF → out_data 1, 2, 0xFFFF, 0xFFFF (saturated), 0xFFFF (saturated). Each appears 2 cycles after input; overflow stays 0.
- Decimation: decim=3, inputs 4, 8, 12, 16, 20, 24, 28 → outputs 1 (from 4), 4 (from 16), 7 (from 28). Change decim to 2 at the 2nd input → takes effect only after the current wrap.
- decim=0 behaves as 1: ramp 0, 4, 8 → outputs 0, 1, 2.
- Backpressure: out_ready=0, decim=1, 6 samples of 4·k (k=1..6):
  - level reaches 4 and out_valid stays 1.
  - Samples 5 and 6 are dropped and overflow=1.
  - Raise out_ready → outputs 1, 2, 3, 4.
  - Pulse clr_ovf → overflow=0.
- Full with simultaneous pop: with the FIFO at 4 entries and out_ready=1 on the same edge as a write → level stays 4 and there is no overflow.
- Async reset mid-stream: assert reset between clock edges with level=3 → out_valid and level go to 0 immediately without waiting for clk. After release, the first valid sample is kept and appears 2 cycles later.
